// File: rtl/axi4_lite_pkg.sv
// Shared AXI response codes and write-master FSM state encoding.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/axi4_write_timeout.sv
// Response timeout counter for axi4_write_master; only built when AXI4_WRITE_TIMEOUT_EN is defined.
`ifdef AXI4_WRITE_TIMEOUT_EN
module axi4_write_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic axi_clk,
    input  logic resetn,
    input  logic start,
    input  logic active,
    input  logic resp_hs,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Count starts at zero in the first SEND cycle, so expiry lands TIMEOUT_CYCLES cycles later.
    always_ff @(posedge axi_clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (active && !resp_hs) begin
            count <= count + CW'(1);
        end
    end

    assign expired = active && !resp_hs && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/axi4_write_master.sv
// Single-outstanding AXI4 write master: one core request becomes one AW/W/B exchange.
// Defining AXI4_WRITE_TIMEOUT_EN adds a response timeout that completes with DECERR.
module axi4_write_master #(
    parameter int ADDRESS_WIDTH  = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     axi_clk,
    input  logic                     resetn,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_data,
    input  logic                     req_valid,
    output logic                     req_ready,
    output logic                     done_valid,
    output logic [1:0]               done_resp,
    output logic [ADDRESS_WIDTH-1:0] write_addr,
    output logic                     write_addr_valid,
    input  logic                     write_addr_ready,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic                     write_data_valid,
    input  logic                     write_data_ready,
    input  logic [1:0]               write_resp,
    input  logic                     write_resp_valid,
    output logic                     write_resp_ready
);
    import axi4_lite_pkg::*;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     aw_valid_q, aw_valid_d;
    logic                     w_valid_q, w_valid_d;
    logic                     b_ready_q, b_ready_d;
    logic                     req_ready_q, req_ready_d;
    logic                     done_valid_q, done_valid_d;
    logic [1:0]               done_resp_q, done_resp_d;
    logic                     accept, aw_hs, w_hs, b_hs, timeout_hit;

    assign accept = req_valid && req_ready_q;
    assign aw_hs  = aw_valid_q && write_addr_ready;
    assign w_hs   = w_valid_q && write_data_ready;
    assign b_hs   = b_ready_q && write_resp_valid;

`ifdef AXI4_WRITE_TIMEOUT_EN
    axi4_write_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .axi_clk (axi_clk),
        .resetn  (resetn),
        .start   (accept),
        .active  (state_q != ST_IDLE),
        .resp_hs (b_hs),
        .expired (timeout_hit)
    );
`else
    // Without the timeout build the parameter has no effect and no counter exists.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // Every output is registered, so all of them read zero while reset is held.
    always_ff @(posedge axi_clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            req_ready_q  <= 1'b0;
            done_valid_q <= 1'b0;
            done_resp_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            b_ready_q    <= b_ready_d;
            req_ready_q  <= req_ready_d;
            done_valid_q <= done_valid_d;
            done_resp_q  <= done_resp_d;
        end
    end

    // AW and W retire independently; RESP follows once neither valid is still pending.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        done_valid_d = 1'b0;
        done_resp_d  = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SEND;
                    addr_d     = req_addr;
                    data_d     = req_data;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                end
            end
            ST_SEND: begin
                if (aw_hs) aw_valid_d = 1'b0;
                if (w_hs)  w_valid_d  = 1'b0;
                if ((!aw_valid_q || aw_hs) && (!w_valid_q || w_hs)) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_d      = ST_IDLE;
                    done_valid_d = 1'b1;
                    done_resp_d  = write_resp;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout_hit) begin
            state_d      = ST_IDLE;
            aw_valid_d   = 1'b0;
            w_valid_d    = 1'b0;
            done_valid_d = 1'b1;
            done_resp_d  = RESP_DECERR;
        end
        req_ready_d = (state_d == ST_IDLE);
        b_ready_d   = (state_d == ST_RESP);
    end

    assign req_ready        = req_ready_q;
    assign done_valid       = done_valid_q;
    assign done_resp        = done_resp_q;
    assign write_addr       = addr_q;
    assign write_addr_valid = aw_valid_q;
    assign write_data       = data_q;
    assign write_data_valid = w_valid_q;
    assign write_resp_ready = b_ready_q;

endmodule

// File: tb/tb_axi4_write_master.sv
// Randomized bench for axi4_write_master against a delay-configurable slave and a memory/latency model.
// Build with AXI4_WRITE_TIMEOUT_EN defined to also exercise the response timeout.
module tb_axi4_write_master;
    localparam int AW = 2;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          axi_clk = 1'b0;
    logic          resetn  = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_valid = 1'b0;
    logic          req_ready, done_valid;
    logic [1:0]    done_resp;
    logic [AW-1:0] write_addr;
    logic          write_addr_valid;
    logic          write_addr_ready = 1'b0;
    logic [DW-1:0] write_data;
    logic          write_data_valid;
    logic          write_data_ready = 1'b0;
    logic [1:0]    write_resp = 2'b00;
    logic          write_resp_valid = 1'b0;
    logic          write_resp_ready;

    axi4_write_master #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .axi_clk(axi_clk), .resetn(resetn),
        .req_addr(req_addr), .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
        .done_valid(done_valid), .done_resp(done_resp),
        .write_addr(write_addr), .write_addr_valid(write_addr_valid), .write_addr_ready(write_addr_ready),
        .write_data(write_data), .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
        .write_resp(write_resp), .write_resp_valid(write_resp_valid), .write_resp_ready(write_resp_ready)
    );

    always #5 axi_clk = ~axi_clk;

    int cyc = 0;
    always @(posedge axi_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Slave configuration and per-transaction observations
    int aw_d_cfg, w_d_cfg, b_d_cfg, resp_cfg;
    int aw_cnt, w_cnt, aw_hs_cnt, w_hs_cnt, aw_first, w_first;
    int b_wait, unstable, bready_early, done_pulses, total_dones, done_cyc, accept_cyc;
    bit aw_done, w_done, b_pend, b_done, mem_written;
    logic [AW-1:0] got_addr, prev_addr;
    logic [DW-1:0] got_data, prev_data;
    logic [1:0]    done_resp_seen;
    logic [DW-1:0] mem     [4];
    logic [DW-1:0] ref_mem [4];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outVector();
        return {23'd0, req_ready, done_valid, done_resp, write_addr_valid, write_data_valid,
                write_resp_ready, write_addr, write_data};
    endfunction

    task automatic clearTxn();
        aw_cnt = 0; w_cnt = 0; aw_done = 0; w_done = 0;
        b_wait = 0; b_pend = 0; b_done = 0; mem_written = 0;
        write_resp_valid = 1'b0;
    endtask

    // Slave: decides readys at the falling edge, which the next rising edge samples.
    task automatic slaveStep();
        if (!resetn) begin
            write_addr_ready = 1'b0;
            write_data_ready = 1'b0;
            clearTxn();
            return;
        end
        if (write_resp_ready && !(aw_done && w_done)) bready_early++;
        if (write_addr_valid) begin
            if (aw_cnt == 0) aw_first = cyc;
            else if (write_addr !== prev_addr) unstable++;
            prev_addr = write_addr;
            aw_cnt++;
            write_addr_ready = (aw_cnt > aw_d_cfg);
            if (write_addr_ready) begin got_addr = write_addr; aw_done = 1; aw_hs_cnt = aw_cnt; end
        end else write_addr_ready = 1'b0;
        if (write_data_valid) begin
            if (w_cnt == 0) w_first = cyc;
            else if (write_data !== prev_data) unstable++;
            prev_data = write_data;
            w_cnt++;
            write_data_ready = (w_cnt > w_d_cfg);
            if (write_data_ready) begin got_data = write_data; w_done = 1; w_hs_cnt = w_cnt; end
        end else write_data_ready = 1'b0;
        if (aw_done && w_done && !mem_written) begin
            mem[got_addr] = got_data;
            mem_written = 1;
        end
        if (b_pend) begin
            write_resp_valid = 1'b0;
            b_pend = 0;
            b_done = 1;
        end else if (aw_done && w_done && !b_done) begin
            if (b_wait >= b_d_cfg) begin
                write_resp_valid = 1'b1;
                write_resp = 2'(resp_cfg);
            end
            b_wait++;
            if (write_resp_valid && write_resp_ready) b_pend = 1;
        end
        if (done_valid) begin
            done_pulses++;
            total_dones++;
            done_resp_seen = done_resp;
            done_cyc = cyc;
            clearTxn();
        end
    endtask

    initial forever begin
        @(negedge axi_clk);
        slaveStep();
    end

    task automatic setCfg(input int awd, input int wd, input int bd, input int rsp);
        aw_d_cfg = awd; w_d_cfg = wd; b_d_cfg = bd; resp_cfg = rsp;
        unstable = 0; bready_early = 0; done_pulses = 0;
        aw_hs_cnt = -1; w_hs_cnt = -1; aw_first = -1; w_first = -1;
    endtask

    task automatic waitReady();
        int n = 0;
        while (!req_ready && n < 50) begin @(negedge axi_clk); #1; n++; end
        checkOutput("req_ready_wait", req_ready, 1);
    endtask

    task automatic waitDone(input int target);
        int n = 0;
        while (total_dones < target && n < 200) begin @(negedge axi_clk); #1; n++; end
        checkOutput("done_wait", total_dones >= target, 1);
    endtask

    task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input int awd, input int wd, input int bd, input int rsp);
        int target;
        setCfg(awd, wd, bd, rsp);
        waitReady();
        target = total_dones + 1;
        req_addr = a; req_data = d; req_valid = 1'b1;
        accept_cyc = cyc + 1;
        @(negedge axi_clk);
        req_valid = 1'b0;
        #1;
        waitDone(target);
        repeat (2) @(negedge axi_clk);
        #1;
    endtask

    task automatic checkTxn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int awd, input int wd, input int bd, input int rsp);
        int lat;
        lat = ((awd > wd) ? awd : wd) + 1 + ((bd > 1) ? bd : 1);
        ref_mem[a] = d;
        checkOutput("resp", done_resp_seen, rsp);
        checkOutput("mem", mem[a], ref_mem[a]);
        checkOutput("aw_addr", got_addr, a);
        checkOutput("aw_valid_cycles", aw_hs_cnt, awd + 1);
        checkOutput("w_valid_cycles", w_hs_cnt, wd + 1);
        checkOutput("aw_first", aw_first, accept_cyc);
        checkOutput("w_first", w_first, accept_cyc);
        checkOutput("latency", done_cyc - accept_cyc, lat);
        checkOutput("pulses", done_pulses, 1);
        checkOutput("stable", unstable, 0);
        checkOutput("bready_early", bready_early, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int awd, wd, bd, rsp, start, rr_bad, n;
        for (int i = 0; i < 4; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        total_dones = 0;
        setCfg(0, 0, 0, 0);
        clearTxn();

        repeat (3) @(negedge axi_clk);
        #1;
        checkOutput("reset_outputs", outVector(), 64'd0);
        resetn = 1'b1;
        #1;
        checkOutput("ready_before_edge", req_ready, 0);
        @(negedge axi_clk);
        #1;
        checkOutput("ready_after_reset", req_ready, 1);

        $display("[TB] basic OKAY write");
        applyStimulus(2'b01, 32'hDEADBEEF, 0, 0, 0, 0);
        checkTxn(2'b01, 32'hDEADBEEF, 0, 0, 0, 0);

        $display("[TB] delayed AW ready");
        applyStimulus(2'b10, 32'h0BAD_F00D, 3, 0, 0, 0);
        checkTxn(2'b10, 32'h0BAD_F00D, 3, 0, 0, 0);

        $display("[TB] SLVERR response");
        applyStimulus(2'b11, 32'h1234_5678, 1, 2, 1, 2);
        checkTxn(2'b11, 32'h1234_5678, 1, 2, 1, 2);

        $display("[TB] back-to-back requests");
        setCfg(0, 0, 0, 0);
        waitReady();
        start = total_dones;
        req_addr = 2'd2; req_data = 32'h1111_2222; req_valid = 1'b1;
        @(negedge axi_clk);
        req_addr = 2'd3; req_data = 32'h3333_4444;
        rr_bad = 0; n = 0;
        while (total_dones == start && n < 100) begin
            if (req_ready) rr_bad++;
            @(negedge axi_clk); #1; n++;
        end
        checkOutput("b2b_ready_low", rr_bad, 0);
        checkOutput("b2b_first_resp", done_resp_seen, 0);
        ref_mem[2] = 32'h1111_2222;
        checkOutput("b2b_first_mem", mem[2], ref_mem[2]);
        @(negedge axi_clk);
        req_valid = 1'b0;
        #1;
        waitDone(start + 2);
        ref_mem[3] = 32'h3333_4444;
        checkOutput("b2b_second_mem", mem[3], ref_mem[3]);
        checkOutput("b2b_pulses", done_pulses, 2);

        $display("[TB] reset during SEND");
        setCfg(6, 6, 0, 0);
        waitReady();
        req_addr = 2'd0; req_data = 32'hCAFE_0000; req_valid = 1'b1;
        @(negedge axi_clk);
        req_valid = 1'b0;
        repeat (2) @(negedge axi_clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("reset_send_outputs", outVector(), 64'd0);
        repeat (3) @(negedge axi_clk);
        #2;
        resetn = 1'b1;
        @(negedge axi_clk);
        #1;
        checkOutput("reset_no_done", done_pulses, 0);
        checkOutput("reset_ready", req_ready, 1);
        applyStimulus(2'b00, 32'hA5A5_5A5A, 0, 1, 0, 1);
        checkTxn(2'b00, 32'hA5A5_5A5A, 0, 1, 0, 1);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 10; i++) begin
            a = AW'($urandom_range(0, 3));
            d = $urandom;
            awd = $urandom_range(0, 3);
            wd = $urandom_range(0, 3);
            bd = $urandom_range(0, 3);
            rsp = $urandom_range(0, 3);
            applyStimulus(a, d, awd, wd, bd, rsp);
            checkTxn(a, d, awd, wd, bd, rsp);
        end

`ifdef AXI4_WRITE_TIMEOUT_EN
        $display("[TB] response timeout");
        applyStimulus(2'b01, 32'h7777_8888, 0, 0, 100000, 0);
        ref_mem[1] = 32'h7777_8888;
        checkOutput("timeout_resp", done_resp_seen, 3);
        checkOutput("timeout_latency", done_cyc - accept_cyc, TO);
        checkOutput("timeout_pulses", done_pulses, 1);
        checkOutput("timeout_idle", req_ready, 1);
        checkOutput("timeout_bready", write_resp_ready, 0);
`endif

        for (int i = 0; i < 4; i++) checkOutput("mem_final", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
